// File: rtl/br_lite_local_ni_pkg.sv
`default_nettype none
// ============================================================================
// Module   : br_lite_local_ni_pkg
// Brief    : BrLite flit/service types and local NI state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package br_lite_local_ni_pkg;

    localparam int BR_ADDR_W    = 16;
    localparam int BR_PAYLOAD_W = 16;
    localparam int BR_ID_W      = 8;

    typedef enum logic [1:0] {
        BR_SVC_CLEAR = 2'd0,
        BR_SVC_ALL   = 2'd1,
        BR_SVC_TGT   = 2'd2,
        BR_SVC_MON   = 2'd3
    } br_svc_t;

    typedef struct packed {
        logic [BR_ADDR_W-1:0]    seq_source;
        logic [BR_ADDR_W-1:0]    seq_target;
        br_svc_t                 service;
        logic [BR_ID_W-1:0]      id;
        logic [BR_PAYLOAD_W-1:0] payload;
    } br_data_t;

    typedef enum logic [3:0] {
        TX_IDLE      = 4'b0001,
        TX_WAIT_FREE = 4'b0010,
        TX_REQ       = 4'b0100,
        TX_RELEASE   = 4'b1000
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'b01,
        RX_WAIT_LOW = 2'b10
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/br_lite_local_ni_if.sv
`default_nettype none
// ============================================================================
// Module   : br_lite_local_ni_if
// Brief    : PE-side and router-side handshake bundle of the local NI.
// Revision : 1.0 - initial release
// ============================================================================
interface br_lite_local_ni_if;
    import br_lite_local_ni_pkg::*;

    logic                    tx_valid_i;
    logic                    tx_ready_o;
    br_svc_t                 tx_service_i;
    logic [BR_ADDR_W-1:0]    tx_target_i;
    logic [BR_PAYLOAD_W-1:0] tx_payload_i;
    logic                    tx_err_o;
    logic                    rx_valid_o;
    logic                    rx_ready_i;
    br_data_t                rx_data_o;
    br_data_t                br_flit_o;
    logic                    br_req_o;
    logic                    br_ack_i;
    logic                    br_busy_i;
    br_data_t                br_flit_i;
    logic                    br_req_i;
    logic                    br_ack_o;

    // slave: the NI itself; master: the PE and router around it
    modport slave (
        input  tx_valid_i, tx_service_i, tx_target_i, tx_payload_i,
               rx_ready_i, br_ack_i, br_busy_i, br_flit_i, br_req_i,
        output tx_ready_o, tx_err_o, rx_valid_o, rx_data_o,
               br_flit_o, br_req_o, br_ack_o
    );

    modport master (
        output tx_valid_i, tx_service_i, tx_target_i, tx_payload_i,
               rx_ready_i, br_ack_i, br_busy_i, br_flit_i, br_req_i,
        input  tx_ready_o, tx_err_o, rx_valid_o, rx_data_o,
               br_flit_o, br_req_o, br_ack_o
    );

endinterface
`default_nettype wire

// File: rtl/br_lite_fifo.sv
`default_nettype none
// ============================================================================
// Module   : br_lite_fifo
// Brief    : Synchronous flit FIFO; head stays on data_o, last value held when empty.
// Revision : 1.0 - initial release
// ============================================================================
module br_lite_fifo
    import br_lite_local_ni_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  br_data_t data_i,
    input  logic     pop_i,
    output br_data_t data_o,
    output logic     valid_o,
    output logic     full_o
);

    localparam int                  c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0]  c_ptr_one = 1;
    localparam logic [c_ptr_w:0]    c_cnt_one = 1;
    localparam logic [c_ptr_w:0]    c_depth   = (c_ptr_w + 1)'(DEPTH);

    br_data_t            r_mem [DEPTH];
    br_data_t            r_last;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w:0]    r_count;
    logic                w_pop;
    logic                w_push;

    assign valid_o = (r_count != '0);
    assign full_o  = (r_count == c_depth);
    assign w_pop   = pop_i & valid_o;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign w_push  = push_i & (~full_o | w_pop);
    assign data_o  = valid_o ? r_mem[r_rd_ptr] : r_last;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/br_lite_local_ni.sv
`default_nettype none
// ============================================================================
// Module   : br_lite_local_ni
// Brief    : PE-side NI for the BrLite router LOCAL port (TX inject, RX buffer).
//            Define BR_LITE_NI_STATS_EN to add tx_count_o / rx_count_o.
// Revision : 1.0 - initial release
// ============================================================================
module br_lite_local_ni
    import br_lite_local_ni_pkg::*;
#(
    parameter logic [15:0] SEQ_ADDRESS = 16'h0000,
    parameter int          RX_DEPTH    = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    br_lite_local_ni_if.slave  ni
`ifdef BR_LITE_NI_STATS_EN
    ,
    output logic [15:0]        tx_count_o,
    output logic [15:0]        rx_count_o
`endif
);

    tx_state_e          r_tx_state;
    tx_state_e          w_tx_next;
    rx_state_e          r_rx_state;
    rx_state_e          w_rx_next;
    br_data_t           r_tx_flit;
    logic [BR_ID_W-1:0] r_id;
    logic               r_tx_err;
    logic               r_run;
    logic               w_tx_ready;
    logic               w_tx_accept;
    logic               w_tx_acked;
    logic               w_br_req;
    logic               w_rx_ack;
    logic               w_rx_can_push;
    logic               w_fifo_full;
    logic               w_fifo_valid;

    // keeps handshake outputs low from reset until the first clock afterwards
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_run <= 1'b0;
        else         r_run <= 1'b1;
    end

    assign w_tx_accept = r_run & (r_tx_state == TX_IDLE) & ni.tx_valid_i;
    assign w_tx_acked  = (r_tx_state == TX_REQ) & ni.br_ack_i;

    always_comb begin
        w_tx_next  = r_tx_state;
        w_tx_ready = 1'b0;
        w_br_req   = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_ready = r_run;
                if (w_tx_accept && ni.tx_service_i != BR_SVC_CLEAR) w_tx_next = TX_WAIT_FREE;
            end
            TX_WAIT_FREE: if (!ni.br_busy_i) w_tx_next = TX_REQ;
            TX_REQ: begin
                w_br_req = 1'b1;
                if (ni.br_ack_i) w_tx_next = TX_RELEASE;
            end
            TX_RELEASE: if (!ni.br_ack_i) w_tx_next = TX_IDLE;
            default:    w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_state <= TX_IDLE;
            r_tx_flit  <= '0;
            r_id       <= '0;
            r_tx_err   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_err   <= w_tx_accept & (ni.tx_service_i == BR_SVC_CLEAR);
            if (w_tx_accept && ni.tx_service_i != BR_SVC_CLEAR) begin
                r_tx_flit <= '{seq_source: SEQ_ADDRESS,
                               seq_target: ni.tx_target_i,
                               service:    ni.tx_service_i,
                               id:         r_id,
                               payload:    ni.tx_payload_i};
            end
            if (w_tx_acked) begin
                r_id <= r_id + 1'b1;
            end
        end
    end

    assign ni.tx_ready_o = w_tx_ready;
    assign ni.tx_err_o   = r_tx_err;
    assign ni.br_req_o   = w_br_req;
    assign ni.br_flit_o  = r_tx_flit;

    // room exists if not full, or the PE pops the head this very cycle
    assign w_rx_can_push = ~w_fifo_full | (ni.rx_ready_i & w_fifo_valid);

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_ack  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_run && ni.br_req_i && w_rx_can_push) begin
                    w_rx_ack  = 1'b1;
                    w_rx_next = RX_WAIT_LOW;
                end
            end
            RX_WAIT_LOW: if (!ni.br_req_i) w_rx_next = RX_IDLE;
            default:     w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_rx_state <= RX_IDLE;
        else         r_rx_state <= w_rx_next;
    end

    assign ni.br_ack_o  = w_rx_ack;
    assign ni.rx_valid_o = w_fifo_valid;

    br_lite_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_rx_ack),
        .data_i  (ni.br_flit_i),
        .pop_i   (ni.rx_ready_i),
        .data_o  (ni.rx_data_o),
        .valid_o (w_fifo_valid),
        .full_o  (w_fifo_full)
    );

`ifdef BR_LITE_NI_STATS_EN
    logic [15:0] r_tx_count;
    logic [15:0] r_rx_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_count <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_tx_acked && r_tx_count != 16'hFFFF) r_tx_count <= r_tx_count + 16'd1;
            if (w_rx_ack   && r_rx_count != 16'hFFFF) r_rx_count <= r_rx_count + 16'd1;
        end
    end

    assign tx_count_o = r_tx_count;
    assign rx_count_o = r_rx_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_br_lite_local_ni.sv
`default_nettype none
// ============================================================================
// Module   : tb_br_lite_local_ni
// Brief    : Directed self-checking bench for br_lite_local_ni (RX_DEPTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_br_lite_local_ni;
    import br_lite_local_ni_pkg::*;

    localparam logic [15:0] c_seq = 16'hBEEF;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk_i = ~clk_i;

    br_lite_local_ni_if bus ();

`ifdef BR_LITE_NI_STATS_EN
    logic [15:0] tx_count;
    logic [15:0] rx_count;
`endif

    br_lite_local_ni #(
        .SEQ_ADDRESS (c_seq),
        .RX_DEPTH    (4)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ni     (bus)
`ifdef BR_LITE_NI_STATS_EN
        ,
        .tx_count_o (tx_count),
        .rx_count_o (rx_count)
`endif
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkf(input string tag, input br_data_t obs, input br_data_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic br_data_t mk(input br_svc_t s, input logic [15:0] src,
                                    input logic [15:0] tgt, input logic [7:0] id,
                                    input logic [15:0] pl);
        br_data_t f;
        f.seq_source = src;
        f.seq_target = tgt;
        f.service    = s;
        f.id         = id;
        f.payload    = pl;
        return f;
    endfunction

    // one PE request, held for exactly the accepting edge
    task automatic send(input br_svc_t s, input logic [15:0] tgt, input logic [15:0] pl);
        bus.tx_valid_i   = 1'b1;
        bus.tx_service_i = s;
        bus.tx_target_i  = tgt;
        bus.tx_payload_i = pl;
        tick();
        bus.tx_valid_i   = 1'b0;
    endtask

    task automatic rtr_push(input string tag, input br_data_t f);
        bus.br_flit_i = f;
        bus.br_req_i  = 1'b1;
        #1;
        chk1(tag, bus.br_ack_o, 1'b1);
        tick();
        bus.br_req_i = 1'b0;
        tick();
    endtask

    br_data_t rf [5];
    br_data_t g;
    br_data_t h;

    initial begin
        for (int i = 0; i < 5; i++) begin
            rf[i] = mk(BR_SVC_TGT, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 8'(i + 8), 16'hD000 + 16'(i));
        end
        g = mk(BR_SVC_MON, 16'h0033, 16'h0044, 8'h55, 16'h6677);
        h = mk(BR_SVC_ALL, 16'h0088, 16'h0099, 8'hAA, 16'hBBCC);

        bus.tx_valid_i   = 1'b0;
        bus.tx_service_i = BR_SVC_ALL;
        bus.tx_target_i  = '0;
        bus.tx_payload_i = '0;
        bus.rx_ready_i   = 1'b0;
        bus.br_ack_i     = 1'b0;
        bus.br_busy_i    = 1'b0;
        bus.br_flit_i    = '0;
        bus.br_req_i     = 1'b0;

        // reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk1("rst_tx_ready", bus.tx_ready_o, 1'b0);
        chk1("rst_tx_err",   bus.tx_err_o,   1'b0);
        chk1("rst_rx_valid", bus.rx_valid_o, 1'b0);
        chk1("rst_br_req",   bus.br_req_o,   1'b0);
        chk1("rst_br_ack",   bus.br_ack_o,   1'b0);
        chkf("rst_br_flit",  bus.br_flit_o,  '0);
        chkf("rst_rx_data",  bus.rx_data_o,  '0);
        rst_ni = 1'b1;
        tick();
        tick();
        chk1("idle_ready", bus.tx_ready_o, 1'b1);

        // send ALL, target 5, payload A5: req two cycles after accept, id 0
        send(BR_SVC_ALL, 16'd5, 16'h00A5);
        chk1("lat_c1_req", bus.br_req_o, 1'b0);
        tick();
        chk1("lat_c2_req", bus.br_req_o, 1'b1);
        chkf("flit0", bus.br_flit_o, mk(BR_SVC_ALL, c_seq, 16'd5, 8'd0, 16'h00A5));
        bus.br_ack_i = 1'b1;
        tick();
        bus.br_ack_i = 1'b0;
        chk1("req_drop", bus.br_req_o, 1'b0);
        chk1("release_not_ready", bus.tx_ready_o, 1'b0);
        tick();
        chk1("back_idle", bus.tx_ready_o, 1'b1);

        // second send carries id 1
        send(BR_SVC_TGT, 16'h0007, 16'h1234);
        tick();
        chk1("send2_req", bus.br_req_o, 1'b1);
        chkf("flit1", bus.br_flit_o, mk(BR_SVC_TGT, c_seq, 16'h0007, 8'd1, 16'h1234));
        bus.br_ack_i = 1'b1;
        tick();
        bus.br_ack_i = 1'b0;
        tick();

        // router busy for 10 cycles holds the request back
        bus.br_busy_i = 1'b1;
        send(BR_SVC_MON, 16'h0009, 16'hC3C3);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("busy_no_req", bus.br_req_o, 1'b0);
        end
        bus.br_busy_i = 1'b0;
        tick();
        chk1("req_after_busy", bus.br_req_o, 1'b1);
        chkf("flit2", bus.br_flit_o, mk(BR_SVC_MON, c_seq, 16'h0009, 8'd2, 16'hC3C3));

        // held ack: req drops and stays low until ack releases
        bus.br_ack_i = 1'b1;
        tick();
        chk1("held_ack_drop", bus.br_req_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("held_ack_req", bus.br_req_o, 1'b0);
            chk1("held_ack_busy", bus.tx_ready_o, 1'b0);
        end
        bus.br_ack_i = 1'b0;
        tick();
        chk1("held_ack_idle", bus.tx_ready_o, 1'b1);
        chk1("held_ack_noreinj", bus.br_req_o, 1'b0);

        // CLEAR: one error pulse, no injection, id untouched
        send(BR_SVC_CLEAR, 16'h0003, 16'hFFFF);
        chk1("clr_err", bus.tx_err_o, 1'b1);
        chk1("clr_req", bus.br_req_o, 1'b0);
        chk1("clr_ready", bus.tx_ready_o, 1'b1);
        tick();
        chk1("clr_err_once", bus.tx_err_o, 1'b0);
        chk1("clr_req2", bus.br_req_o, 1'b0);
        send(BR_SVC_ALL, 16'h0001, 16'h0101);
        tick();
        chkf("flit3_id", bus.br_flit_o, mk(BR_SVC_ALL, c_seq, 16'h0001, 8'd3, 16'h0101));
        bus.br_ack_i = 1'b1;
        tick();
        bus.br_ack_i = 1'b0;
        tick();

        // RX: fill the 4-entry FIFO with no pops
        rtr_push("rx_ack0", rf[0]);
        rtr_push("rx_ack1", rf[1]);
        rtr_push("rx_ack2", rf[2]);
        rtr_push("rx_ack3", rf[3]);
        chk1("rx_valid_full", bus.rx_valid_o, 1'b1);
        chkf("rx_head0", bus.rx_data_o, rf[0]);

        // 5th flit waits while full
        bus.br_flit_i = rf[4];
        bus.br_req_i  = 1'b1;
        #1;
        chk1("rx_full_noack", bus.br_ack_o, 1'b0);
        tick();
        chk1("rx_full_noack2", bus.br_ack_o, 1'b0);
        tick();
        chk1("rx_full_noack3", bus.br_ack_o, 1'b0);

        // a pop frees the slot in the same cycle
        bus.rx_ready_i = 1'b1;
        #1;
        chk1("rx_ack_on_pop", bus.br_ack_o, 1'b1);
        chkf("rx_pop0", bus.rx_data_o, rf[0]);
        tick();
        bus.rx_ready_i = 1'b0;
        bus.br_req_i   = 1'b0;
        #1;
        chk1("rx_ack_once", bus.br_ack_o, 1'b0);
        tick();

        bus.rx_ready_i = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chkf("rx_pop_order", bus.rx_data_o, rf[i]);
            tick();
        end
        bus.rx_ready_i = 1'b0;
        chk1("rx_empty", bus.rx_valid_o, 1'b0);
        chkf("rx_hold_last", bus.rx_data_o, rf[4]);

        // req held 3 cycles after ack: single push only
        bus.br_flit_i = g;
        bus.br_req_i  = 1'b1;
        #1;
        chk1("hold_ack", bus.br_ack_o, 1'b1);
        tick();
        bus.br_flit_i = h;
        for (int i = 0; i < 3; i++) begin
            chk1("hold_no_ack", bus.br_ack_o, 1'b0);
            tick();
        end
        bus.br_req_i = 1'b0;
        tick();
        bus.br_req_i = 1'b1;
        #1;
        chk1("next_ack", bus.br_ack_o, 1'b1);
        tick();
        bus.br_req_i = 1'b0;
        tick();
        chkf("hold_head_g", bus.rx_data_o, g);
        bus.rx_ready_i = 1'b1;
        tick();
        chkf("hold_head_h", bus.rx_data_o, h);
        chk1("hold_valid_h", bus.rx_valid_o, 1'b1);
        tick();
        bus.rx_ready_i = 1'b0;
        chk1("hold_only_two", bus.rx_valid_o, 1'b0);

        // asynchronous reset mid-transaction
        rtr_push("pre_rst_push", rf[2]);
        send(BR_SVC_ALL, 16'h0002, 16'h5A5A);
        tick();
        chk1("pre_rst_req", bus.br_req_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk1("mid_rst_req", bus.br_req_o, 1'b0);
        chk1("mid_rst_rx_valid", bus.rx_valid_o, 1'b0);
        chkf("mid_rst_flit", bus.br_flit_o, '0);
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        send(BR_SVC_ALL, 16'h0002, 16'h5A5A);
        tick();
        chkf("post_rst_id0", bus.br_flit_o, mk(BR_SVC_ALL, c_seq, 16'h0002, 8'd0, 16'h5A5A));
        bus.br_ack_i = 1'b1;
        tick();
        bus.br_ack_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/br_lite_local_ni.md
Name: br_lite_local_ni

Overview:
Local-port network interface for the BrLite broadcast router; it is the PE-side peer of the router's LOCAL port.
- TX path: takes send requests from the PE, builds a flit, injects it on the router LOCAL input with req/ack.
- RX path: accepts flits the router delivers on its LOCAL output with req/ack, buffers them in a small FIFO and presents them to the PE with valid/ready.

Parameters:
SEQ_ADDRESS, 16'h0000, sequential address of this PE; written into seq_source of every injected flit.
RX_DEPTH, 4, RX FIFO depth in entries; power of 2, minimum 2.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
tx_valid_i  in  1  PE send request
tx_ready_o  out  1  NI accepts the send request this cycle
tx_service_i  in  br_svc_t  requested service (ALL/TGT/MON)
tx_target_i  in  16  seq_target field
tx_payload_i  in  payload width of br_data_t  payload field
tx_err_o  out  1  one-cycle pulse: request rejected (service CLEAR)
rx_valid_o  out  1  FIFO head valid
rx_ready_i  in  1  PE pops FIFO head
rx_data_o  out  br_data_t  FIFO head flit
br_flit_o  out  br_data_t  flit to router LOCAL input
br_req_o  out  1  req to router LOCAL input
br_ack_i  in  1  ack from router LOCAL input
br_busy_i  in  1  router local_busy (local write not yet cleared)
br_flit_i  in  br_data_t  flit from router LOCAL output
br_req_i  in  1  req from router LOCAL output
br_ack_o  out  1  ack to router LOCAL output

Behaviour:
Reset values: all outputs 0, id counter 0, RX FIFO empty, TX FSM in TX_IDLE, RX FSM in RX_IDLE.

TX FSM states and transitions:
- TX_IDLE
  - tx_ready_o = 1.
  - tx_valid_i and service == CLEAR: request consumed, tx_err_o pulses next cycle, state stays TX_IDLE.
  - tx_valid_i and any other service: capture the flit into a register, then go to TX_WAIT_FREE.
- TX_WAIT_FREE: wait while br_busy_i = 1; when br_busy_i = 0, go to TX_REQ.
- TX_REQ
  - br_req_o = 1; br_flit_o holds stable.
  - On br_ack_i = 1: drop req next cycle, increment id, go to TX_RELEASE.
- TX_RELEASE: br_req_o = 0; wait for br_ack_i = 0, then go to TX_IDLE. Both one-cycle acks and held acks are tolerated.

TX flit contents:
- Fields: seq_source = SEQ_ADDRESS, seq_target = tx_target_i, service = tx_service_i, payload = tx_payload_i, id = id counter.
- br_flit_o is registered at acceptance and held constant until TX_IDLE is re-entered.

TX latency and id counter:
- Minimum latency from accept to br_req_o: 2 cycles.
- Id counter width matches the br_data_t id field; it wraps modulo 2^width with no flag.

RX FSM states and transitions:
- RX_IDLE: when br_req_i = 1 and the FIFO is not full, push br_flit_i, drive br_ack_o = 1 for exactly one cycle, go to RX_WAIT_LOW.
- RX_WAIT_LOW: br_ack_o = 0; return to RX_IDLE only after sampling br_req_i = 0. This guarantees one push per router transaction.

RX boundary conditions:
- FIFO full with br_req_i = 1: no ack is given; the router holds req until space frees.
- Push and pop in the same cycle on a full FIFO: allowed only when a pop frees the slot that cycle. The full check uses the pre-pop count plus rx_ready_i & rx_valid_o.
- rx_data_o is the FIFO head.
- FIFO pointers are log2(RX_DEPTH) bits and wrap; the count is one bit wider.
- Empty FIFO: rx_valid_o = 0 and rx_data_o holds its last value.

Concurrency and reset:
- TX and RX run independently.
- Asynchronous reset mid-transaction returns both FSMs to idle, drops req/ack, flushes the FIFO and discards the pending TX flit.

Optional Feature:
BR_LITE_NI_STATS_EN
- When defined, adds outputs tx_count_o[15:0] (flits acked by the router) and rx_count_o[15:0] (flits pushed).
- Both counters reset to 0 and saturate at 16'hFFFF.
- When undefined, these ports and counters do not exist.

Decomposition:
- BrLitePkg holds br_data_t, br_svc_t and the BR_SVC_* constants.
- Add to BrLitePkg: the TX/RX state enums (one-hot) and the id width constant.
- One natural sub-module: br_lite_fifo, a generic synchronous FIFO of br_data_t with parameter DEPTH, used for the RX buffer.

Test Plan:
- Send ALL, target 5, payload 0xA5 with br_busy_i = 0:
  - br_req_o rises 2 cycles after accept; flit seq_source = SEQ_ADDRESS, id = 0.
  - One-cycle ack → req low next cycle, back to TX_IDLE; the second send carries id = 1.
- br_busy_i held high for 10 cycles: br_req_o stays 0 throughout; req asserts the cycle after busy falls.
- Held ack (ack asserted until req drops): NI drops req and waits in TX_RELEASE; no second injection occurs.
- tx_service_i = CLEAR: tx_err_o pulses once, br_req_o never asserts, id unchanged.
- Router presents 5 flits with rx_ready_i = 0, RX_DEPTH = 4:
  - The first 4 are acked one cycle each; the 5th req gets no ack.
  - One pop → 5th is acked; data pops in order.
- Router keeps br_req_i high 3 cycles after ack: exactly one push occurs; the next flit is accepted only after req returns to 0.
